// File: rtl/instr_fetch_ctrl_if.sv
// Fetch-controller bundle: transmitter request/ack
// side plus the consumer-facing show-ahead FIFO port.
interface instr_fetch_ctrl_if #(
  parameter int IWIDTH = 32
);
  logic              f_i_start;
  logic              f_i_pause;
  logic              f_o_syn;
  logic              f_i_ack;
  logic [IWIDTH-1:0] f_i_instr;
  logic [IWIDTH-1:0] f_o_instr;
  logic              f_o_valid;
  logic              f_i_ready;
  logic              f_o_done;
  logic              f_o_err;

  modport slave (
    input  f_i_start,
    input  f_i_pause,
    input  f_i_ack,
    input  f_i_instr,
    input  f_i_ready,
    output f_o_syn,
    output f_o_instr,
    output f_o_valid,
    output f_o_done,
    output f_o_err
  );

  modport master (
    output f_i_start,
    output f_i_pause,
    output f_i_ack,
    output f_i_instr,
    output f_i_ready,
    input  f_o_syn,
    input  f_o_instr,
    input  f_o_valid,
    input  f_o_done,
    input  f_o_err
  );
endinterface

// File: rtl/instr_fetch_ctrl.sv
// Instruction fetch controller: paces transmitter
// requests against free slots of a prefetch FIFO.
module instr_fetch_ctrl #(
  parameter int IWIDTH    = 32,
  parameter int NUM_INSTR = 36,
  parameter int FDEPTH    = 4
) (
  input  logic f_clk,
  input  logic f_rst,
  instr_fetch_ctrl_if.slave bus
);
  localparam int CW = $clog2(NUM_INSTR + 1);
  localparam int PW = $clog2(FDEPTH);
  localparam int RW = $clog2(FDEPTH + 1);
  localparam logic [CW-1:0] LAST  = CW'(NUM_INSTR - 1);
  localparam logic [CW-1:0] TOTAL = CW'(NUM_INSTR);
  localparam logic [CW-1:0] C1    = CW'(1);
  localparam logic [RW-1:0] FULL  = RW'(FDEPTH);
  localparam logic [RW-1:0] R1    = RW'(1);
  localparam logic [PW-1:0] P1    = PW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    DRAIN,
    DONE
  } state_t;

  state_t            state;
  state_t            nxt;
  logic              enter;
  logic [CW-1:0]     issued;
  logic [RW-1:0]     reserved;
  logic [RW-1:0]     count;
  logic [1:0]        outst;
  logic [PW-1:0]     wptr;
  logic [PW-1:0]     rptr;
  logic [IWIDTH-1:0] mem [FDEPTH];
  logic              syn;
  logic              err;
  logic              pop;
  logic              push;
  logic              bad_ack;
  logic              issue;

  assign pop     = (count != '0) && bus.f_i_ready;
  assign push    = bus.f_i_ack && (outst != 2'd0);
  assign bad_ack = bus.f_i_ack && (outst == 2'd0);
  // A pop this cycle frees a slot for a new request.
  assign issue   = (state == FETCH)
                && !bus.f_i_pause
                && ((reserved != FULL) || pop)
                && (issued != TOTAL);

  // State register.
  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) state <= IDLE;
    else       state <= nxt;
  end

  // Next-state logic; enter marks a fresh pass.
  always_comb begin
    nxt   = state;
    enter = 1'b0;
    unique case (state)
      IDLE, DONE: begin
        if (bus.f_i_start) begin
          nxt   = FETCH;
          enter = 1'b1;
        end
      end
      FETCH: begin
        if (issue && (issued == LAST)) nxt = DRAIN;
      end
      DRAIN: begin
        if ((outst == 2'd0) && (count == '0))
          nxt = DONE;
      end
      default: nxt = IDLE;
    endcase
  end

  // Request pacing, counters, FIFO pointers, error flag.
  always_ff @(posedge f_clk or posedge f_rst) begin
    if (f_rst) begin
      syn      <= 1'b0;
      issued   <= '0;
      reserved <= '0;
      outst    <= 2'd0;
      count    <= '0;
      wptr     <= '0;
      rptr     <= '0;
      err      <= 1'b0;
    end else begin
      syn <= issue;
      if (enter)      issued <= '0;
      else if (issue) issued <= issued + C1;
      if (issue && !pop)      reserved <= reserved + R1;
      else if (pop && !issue) reserved <= reserved - R1;
      if (issue && !push)      outst <= outst + 2'd1;
      else if (push && !issue) outst <= outst - 2'd1;
      if (push && !pop)      count <= count + R1;
      else if (pop && !push) count <= count - R1;
      if (push) wptr <= wptr + P1;
      if (pop)  rptr <= rptr + P1;
      if (bad_ack) err <= 1'b1;
    end
  end

  // FIFO storage; contents are masked while empty.
  always_ff @(posedge f_clk) begin
    if (push) mem[wptr] <= bus.f_i_instr;
  end

  assign bus.f_o_syn   = syn;
  assign bus.f_o_valid = (count != '0);
  assign bus.f_o_instr = (count != '0) ? mem[rptr] : '0;
  assign bus.f_o_done  = (state == DONE);
  assign bus.f_o_err   = err;
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Bench for instr_fetch_ctrl: transmitter model,
// scoreboard of acked data and directed scenarios.
module tb_instr_fetch_ctrl;
  localparam int N  = 36;
  localparam int FD = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  instr_fetch_ctrl_if #(.IWIDTH(32)) bus ();

  instr_fetch_ctrl #(
    .IWIDTH(32),
    .NUM_INSTR(N),
    .FDEPTH(FD)
  ) dut (
    .f_clk(clk),
    .f_rst(rst),
    .bus(bus)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic pend;
  logic inject;
  int   tx_idx;

  logic [31:0] q[$];
  int   inflight;
  logic exp_err;
  int   npop;
  int   pass_pop;
  int   pass_syn;
  int   run;
  int   max_run;

  task automatic check(string name,
                       logic [63:0] act,
                       logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h",
               name, act, exp);
    end
  endtask

  // Transmitter: acks one cycle after it samples syn.
  initial begin
    pend          = 1'b0;
    inject        = 1'b0;
    tx_idx        = 0;
    bus.f_i_ack   = 1'b0;
    bus.f_i_instr = '0;
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        pend        = 1'b0;
        tx_idx      = 0;
        bus.f_i_ack = 1'b0;
      end else begin
        bus.f_i_ack = pend | inject;
        if (pend) begin
          bus.f_i_instr = 32'h100 + tx_idx;
          tx_idx = (tx_idx + 1) % N;
        end else begin
          bus.f_i_instr = 32'hDEAD_BEEF;
        end
        pend = bus.f_o_syn;
      end
    end
  end

  // Scoreboard and per-cycle comparison.
  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      inflight = 0;
      exp_err  = 1'b0;
      npop     = 0;
      run      = 0;
    end else begin
      check("valid", bus.f_o_valid, q.size() != 0);
      if (q.size() != 0)
        check("head", bus.f_o_instr, q[0]);
      check("err", bus.f_o_err, exp_err);
      check("reserve",
            (q.size() + inflight + bus.f_o_syn) <= FD,
            1);
      if (bus.f_i_ack) begin
        if (inflight == 0) exp_err = 1'b1;
        else begin
          inflight--;
          q.push_back(bus.f_i_instr);
        end
      end
      if (bus.f_o_valid && bus.f_i_ready) begin
        check("pop", bus.f_o_instr,
              32'h100 + (npop % N));
        if (q.size() != 0) void'(q.pop_front());
        npop++;
        pass_pop++;
      end
      if (bus.f_o_syn) begin
        inflight++;
        pass_syn++;
        run++;
        if (run > max_run) max_run = run;
      end else begin
        run = 0;
      end
    end
  end

  task automatic start_pass();
    pass_pop = 0;
    pass_syn = 0;
    max_run  = 0;
    @(posedge clk);
    #1 bus.f_i_start = 1'b1;
    @(posedge clk);
    #1 bus.f_i_start = 1'b0;
  endtask

  task automatic wait_done(int max);
    for (int i = 0; i < max; i++) begin
      @(negedge clk);
      if (bus.f_o_done) break;
    end
    check("done", bus.f_o_done, 1);
  endtask

  task automatic check_zero(string tag);
    check({tag, "_syn"},   bus.f_o_syn,   0);
    check({tag, "_valid"}, bus.f_o_valid, 0);
    check({tag, "_done"},  bus.f_o_done,  0);
    check({tag, "_err"},   bus.f_o_err,   0);
    check({tag, "_instr"}, bus.f_o_instr, 0);
  endtask

  initial begin
    bus.f_i_start = 1'b0;
    bus.f_i_pause = 1'b0;
    bus.f_i_ready = 1'b1;
    #3;
    check_zero("rst0");
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Streaming pass.
    start_pass();
    wait_done(200);
    check("s_pops", pass_pop, 36);
    check("s_syns", pass_syn, 36);
    check("s_run",  max_run,  36);
    check("s_err",  bus.f_o_err, 0);

    // Rerun with a 5-cycle pause.
    start_pass();
    repeat (8) @(posedge clk);
    #1 bus.f_i_pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1 check("p_syn", bus.f_o_syn, 0);
    end
    bus.f_i_pause = 1'b0;
    wait_done(200);
    check("p_pops",  pass_pop, 36);
    check("p_total", npop, 72);

    // Backpressure.
    bus.f_i_ready = 1'b0;
    start_pass();
    repeat (20) @(negedge clk);
    check("b_syns",  pass_syn, 4);
    check("b_valid", bus.f_o_valid, 1);
    check("b_syn",   bus.f_o_syn, 0);
    check("b_pops",  pass_pop, 0);
    @(posedge clk);
    #1 bus.f_i_ready = 1'b1;
    @(posedge clk);
    #1 check("b_resume", bus.f_o_syn, 1);
    wait_done(200);
    check("b_pops2", pass_pop, 36);
    check("b_total", npop, 108);

    // Reset mid-pass after 10 pops.
    start_pass();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pass_pop >= 10) break;
    end
    check("r_ten", pass_pop, 10);
    #2 rst = 1'b1;
    #1 check_zero("rstm");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("r_idle", bus.f_o_done, 0);
    start_pass();
    wait_done(200);
    check("r_pops", pass_pop, 36);
    check("r_total", npop, 36);

    // Spurious ack in IDLE.
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #3 inject = 1'b1;
    @(posedge clk);
    #2 inject = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("e_err",   bus.f_o_err, 1);
    check("e_valid", bus.f_o_valid, 0);
    repeat (5) @(negedge clk);
    check("e_sticky", bus.f_o_err, 1);
    #2 rst = 1'b1;
    #1 check("e_clear", bus.f_o_err, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end
endmodule
